// File: rtl/clock_mode_ctrl.sv
// Front-panel controller for the alarm clock datapath.
// Two buttons, mode and adv, step through the time and alarm set states and
// produce the advance strobes that the counters consume. A second FSM runs the
// alarm ring/snooze sequence.
//
// panel state | meaning
// ------------+----------------------------------------------
// RUN         | normal timekeeping, adv ignored
// T_MIN       | set time minutes (minadv)
// T_HRS       | set time hours (hrsadv)
// T_DAY       | set day (dayadv)
// A_MIN       | set alarm minutes (minadv)
// A_HRS       | set alarm hours (hrsadv)
//
// alarm state | meaning
// ------------+----------------------------------------------
// A_IDLE      | quiet, waiting for a match while panel is RUN
// A_RING      | buzzer on, stops by itself after RING_SEC ticks
// A_SNOOZE    | buzzer paused, resumes after SNOOZE_SEC ticks

module clock_mode_ctrl #(
    parameter int RPT_DLY    = 2,
    parameter int IDLE_TO    = 30,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 540
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       mode_btn,
    input  logic       adv_btn,
    input  logic       snooze_btn,
    input  logic       alarm_sw,
    input  logic       alarm_match,
    output logic       timeset,
    output logic       alarmset,
    output logic       minadv,
    output logic       hrsadv,
    output logic       dayadv,
    output logic [2:0] mode,
    output logic       buzz,
    output logic       snoozing
);

    localparam int RS_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int RSW    = $clog2(RS_MAX + 1);
    localparam int IW     = $clog2(IDLE_TO + 1);
    localparam int RW     = $clog2(RPT_DLY + 1);

    // Terminal counts: the counters leave their state on the tick that would
    // make them equal the full period, so they never exceed period-1.
    localparam logic [RSW-1:0] RING_LAST   = RSW'(RING_SEC - 1);
    localparam logic [RSW-1:0] SNOOZE_LAST = RSW'(SNOOZE_SEC - 1);
    localparam logic [IW-1:0]  IDLE_LAST   = IW'(IDLE_TO - 1);
    localparam logic [RW-1:0]  RPT_FULL    = RW'(RPT_DLY);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        T_MIN = 3'd1,
        T_HRS = 3'd2,
        T_DAY = 3'd3,
        A_MIN = 3'd4,
        A_HRS = 3'd5
    } panel_t;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_RING   = 2'd1,
        A_SNOOZE = 2'd2
    } alarm_t;

    panel_t         panel;
    panel_t         panel_nxt;
    alarm_t         alarm;
    alarm_t         alarm_nxt;

    logic           armed;
    logic           mode_q;
    logic           adv_q;
    logic           snooze_q;
    logic           match_q;

    logic           mode_rise;
    logic           adv_rise;
    logic           snooze_rise;
    logic           match_rise;

    logic [IW-1:0]  idle_cnt;
    logic [RW-1:0]  rpt_cnt;
    logic [RSW-1:0] rs_cnt;

    logic           idle_expire;
    logic           rpt_fire;
    logic           adv_req;
    logic           stay_set;

    function automatic panel_t step_panel(input panel_t p);
        case (p)
            RUN:     step_panel = T_MIN;
            T_MIN:   step_panel = T_HRS;
            T_HRS:   step_panel = T_DAY;
            T_DAY:   step_panel = A_MIN;
            A_MIN:   step_panel = A_HRS;
            default: step_panel = RUN;
        endcase
    endfunction

    // Previous-clk button values; armed stays low for the first clk after
    // reset so a button already held at release does not count as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed    <= 1'b0;
            mode_q   <= 1'b0;
            adv_q    <= 1'b0;
            snooze_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            armed    <= 1'b1;
            mode_q   <= mode_btn;
            adv_q    <= adv_btn;
            snooze_q <= snooze_btn;
            match_q  <= alarm_match;
        end
    end

    assign mode_rise   = armed & mode_btn    & ~mode_q;
    assign adv_rise    = armed & adv_btn     & ~adv_q;
    assign snooze_rise = armed & snooze_btn  & ~snooze_q;
    assign match_rise  = armed & alarm_match & ~match_q;

    // Idle timeout can only fire while adv is released, because a held adv
    // keeps the idle counter cleared.
    assign idle_expire = sec_tick & ~adv_btn & (idle_cnt == IDLE_LAST);
    assign rpt_fire    = adv_btn & sec_tick & (rpt_cnt == RPT_FULL);

    // Panel next state: a mode edge beats timeout, which beats any strobe.
    always_comb begin
        panel_nxt = RUN;
        adv_req   = 1'b0;
        case (panel)
            RUN: begin
                panel_nxt = mode_rise ? T_MIN : RUN;
            end
            T_MIN, T_HRS, T_DAY, A_MIN, A_HRS: begin
                if (mode_rise) begin
                    panel_nxt = step_panel(panel);
                end else if (idle_expire) begin
                    panel_nxt = RUN;
                end else begin
                    panel_nxt = panel;
                    adv_req   = adv_rise | rpt_fire;
                end
            end
            default: begin
                panel_nxt = RUN;
            end
        endcase
    end

    assign stay_set = (panel != RUN) && (panel_nxt == panel) && !mode_rise;

    // Panel state, its registered decodes, advance strobes and the
    // idle/repeat counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            panel    <= RUN;
            mode     <= 3'd0;
            timeset  <= 1'b0;
            alarmset <= 1'b0;
            minadv   <= 1'b0;
            hrsadv   <= 1'b0;
            dayadv   <= 1'b0;
            idle_cnt <= '0;
            rpt_cnt  <= '0;
        end else begin
            panel    <= panel_nxt;
            mode     <= panel_nxt;
            timeset  <= (panel_nxt == T_MIN) || (panel_nxt == T_HRS) ||
                        (panel_nxt == T_DAY);
            alarmset <= (panel_nxt == A_MIN) || (panel_nxt == A_HRS);
            minadv   <= adv_req && ((panel == T_MIN) || (panel == A_MIN));
            hrsadv   <= adv_req && ((panel == T_HRS) || (panel == A_HRS));
            dayadv   <= adv_req && (panel == T_DAY);

            if (!stay_set || adv_btn) begin
                idle_cnt <= '0;
            end else if (sec_tick) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // The edge clk does not count a tick; counting starts the clk after.
            if (!stay_set || !adv_btn || adv_rise) begin
                rpt_cnt <= '0;
            end else if (sec_tick && (rpt_cnt != RPT_FULL)) begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

    // Alarm next state; a low alarm_sw overrides every other transition.
    always_comb begin
        alarm_nxt = alarm;
        case (alarm)
            A_IDLE: begin
                if (match_rise && (panel == RUN)) begin
                    alarm_nxt = A_RING;
                end
            end
            A_RING: begin
                if (snooze_rise) begin
                    alarm_nxt = A_SNOOZE;
                end else if (sec_tick && (rs_cnt == RING_LAST)) begin
                    alarm_nxt = A_IDLE;
                end
            end
            A_SNOOZE: begin
                if (sec_tick && (rs_cnt == SNOOZE_LAST)) begin
                    alarm_nxt = A_RING;
                end
            end
            default: begin
                alarm_nxt = A_IDLE;
            end
        endcase
        if (!alarm_sw) begin
            alarm_nxt = A_IDLE;
        end
    end

    // Alarm state, shared ring/snooze counter and buzzer outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm    <= A_IDLE;
            rs_cnt   <= '0;
            buzz     <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            alarm    <= alarm_nxt;
            buzz     <= (alarm_nxt == A_RING);
            snoozing <= (alarm_nxt == A_SNOOZE);
            if ((alarm_nxt != alarm) || (alarm == A_IDLE)) begin
                rs_cnt <= '0;
            end else if (sec_tick) begin
                rs_cnt <= rs_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Testbench for clock_mode_ctrl: directed panel/alarm sequences followed by
// random button activity, all checked against a behavioural model through an
// expected-output queue.

module tb_clock_mode_ctrl;

    localparam int RPT_DLY    = 2;
    localparam int IDLE_TO    = 30;
    localparam int RING_SEC   = 60;
    localparam int SNOOZE_SEC = 540;

    logic       clk;
    logic       rst_b;
    logic       tick;
    logic       mode_b;
    logic       adv_b;
    logic       snz_b;
    logic       sw;
    logic       match;
    logic       timeset;
    logic       alarmset;
    logic       minadv;
    logic       hrsadv;
    logic       dayadv;
    logic [2:0] mode;
    logic       buzz;
    logic       snoozing;

    clock_mode_ctrl #(
        .RPT_DLY    (RPT_DLY),
        .IDLE_TO    (IDLE_TO),
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC)
    ) dut (
        .clk         (clk),
        .rst         (rst_b),
        .sec_tick    (tick),
        .mode_btn    (mode_b),
        .adv_btn     (adv_b),
        .snooze_btn  (snz_b),
        .alarm_sw    (sw),
        .alarm_match (match),
        .timeset     (timeset),
        .alarmset    (alarmset),
        .minadv      (minadv),
        .hrsadv      (hrsadv),
        .dayadv      (dayadv),
        .mode        (mode),
        .buzz        (buzz),
        .snoozing    (snoozing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_min = 0;
    int n_hrs = 0;
    int n_day = 0;

    logic [9:0] exp_q[$];

    // Behavioural model: panel as an index 0..5, alarm as 0/1/2 with a
    // countdown of seconds remaining.
    int m_p = 0;
    int m_idle = 0;
    int m_held = 0;
    int m_a = 0;
    int m_rem = 0;
    bit m_armed = 0;
    bit pm = 0, pa = 0, ps = 0, px = 0;

    task automatic ref_step(output logic [9:0] e);
        bit mr, ar, sr, xr, stb;
        int old;
        if (!rst_b) begin
            m_p = 0; m_idle = 0; m_held = 0; m_a = 0; m_rem = 0;
            m_armed = 0; pm = 0; pa = 0; ps = 0; px = 0;
            e = '0;
        end else begin
            mr  = m_armed && mode_b && !pm;
            ar  = m_armed && adv_b && !pa;
            sr  = m_armed && snz_b && !ps;
            xr  = m_armed && match && !px;
            old = m_p;
            stb = 0;
            if (mr) begin
                m_p = (m_p + 1) % 6;
                m_idle = 0;
                m_held = 0;
            end else if (m_p != 0) begin
                if (adv_b) m_idle = 0;
                else if (tick) m_idle++;
                if (m_idle >= IDLE_TO) begin
                    m_p = 0; m_idle = 0; m_held = 0;
                end else if (ar) begin
                    stb = 1; m_held = 0;
                end else if (!adv_b) begin
                    m_held = 0;
                end else if (tick) begin
                    if (m_held >= RPT_DLY) stb = 1;
                    else m_held++;
                end
            end
            if (!sw) begin
                m_a = 0;
            end else begin
                case (m_a)
                    0: if (xr && old == 0) begin m_a = 1; m_rem = RING_SEC; end
                    1: begin
                        if (sr) begin
                            m_a = 2; m_rem = SNOOZE_SEC;
                        end else if (tick) begin
                            m_rem--;
                            if (m_rem == 0) m_a = 0;
                        end
                    end
                    default: begin
                        if (tick) begin
                            m_rem--;
                            if (m_rem == 0) begin m_a = 1; m_rem = RING_SEC; end
                        end
                    end
                endcase
            end
            e = {(m_p inside {1, 2, 3}), (m_p inside {4, 5}),
                 (stb && (m_p == 1 || m_p == 4)), (stb && (m_p == 2 || m_p == 5)),
                 (stb && m_p == 3), 3'(m_p), (m_a == 1), (m_a == 2)};
            pm = mode_b; pa = adv_b; ps = snz_b; px = match;
            m_armed = 1;
        end
    endtask

    // Called at a negedge with the inputs for the next posedge already set.
    task automatic cyc();
        logic [9:0] e;
        ref_step(e);
        exp_q.push_back(e);
        @(negedge clk);
        n_min += int'(minadv);
        n_hrs += int'(hrsadv);
        n_day += int'(dayadv);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press_mode();
        mode_b = 1'b1;
        cyc();
        mode_b = 1'b0;
        cyc();
    endtask

    task automatic zero_counts();
        n_min = 0; n_hrs = 0; n_day = 0;
    endtask

    // Monitor: compares every registered output vector against the queue.
    initial begin
        logic [9:0] e;
        logic [9:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {timeset, alarmset, minadv, hrsadv, dayadv, mode, buzz, snoozing};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got %b expected %b", $time, a, e);
                end
            end
        end
    end

    initial begin
        rst_b = 1'b0; tick = 1'b0; mode_b = 1'b1; adv_b = 1'b0;
        snz_b = 1'b0; sw = 1'b0; match = 1'b0;
        cyc();
        cyc();
        chk("reset_mode", 32'(mode), 0);
        chk("reset_buzz", 32'(buzz), 0);

        // mode held through reset release must not step the panel
        rst_b = 1'b1;
        cyc(); cyc(); cyc();
        chk("held_at_release", 32'(mode), 0);
        mode_b = 1'b0;
        cyc();

        for (int i = 1; i <= 6; i++) begin
            mode_b = 1'b1;
            cyc();
            chk("mode_step", 32'(mode), 32'(i % 6));
            chk("timeset", 32'(timeset), 32'((i % 6) inside {1, 2, 3}));
            chk("alarmset", 32'(alarmset), 32'((i % 6) inside {4, 5}));
            mode_b = 1'b0;
            cyc();
        end

        // adv tap in RUN: no strobe
        zero_counts();
        adv_b = 1'b1; cyc(); cyc(); cyc();
        adv_b = 1'b0; cyc(); cyc();
        chk("run_tap_strobes", 32'(n_min + n_hrs + n_day), 0);

        // adv tap in T_MIN: exactly one minadv
        press_mode();
        zero_counts();
        adv_b = 1'b1; cyc(); cyc(); cyc();
        adv_b = 1'b0; cyc(); cyc();
        chk("tmin_tap_minadv", 32'(n_min), 1);
        chk("tmin_tap_other", 32'(n_hrs + n_day), 0);

        // auto-repeat in A_HRS across six ticks
        repeat (4) press_mode();
        chk("at_ahrs", 32'(mode), 5);
        zero_counts();
        adv_b = 1'b1;
        cyc();
        for (int k = 0; k < 6; k++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
        adv_b = 1'b0; cyc(); cyc();
        chk("repeat_hrsadv", 32'(n_hrs), 5);
        chk("repeat_other", 32'(n_min + n_day), 0);

        // idle timeout in T_DAY
        repeat (4) press_mode();
        chk("at_tday", 32'(mode), 3);
        zero_counts();
        for (int k = 1; k <= IDLE_TO; k++) begin
            tick = 1'b1; cyc();
            tick = 1'b0;
            if (k == IDLE_TO - 1) chk("before_timeout", 32'(mode), 3);
            if (k < IDLE_TO) cyc();
        end
        chk("after_timeout", 32'(mode), 0);
        chk("timeout_no_dayadv", 32'(n_day), 0);
        cyc();

        // simultaneous mode and adv edges
        press_mode();
        zero_counts();
        mode_b = 1'b1; adv_b = 1'b1;
        cyc();
        chk("simul_mode", 32'(mode), 2);
        mode_b = 1'b0; adv_b = 1'b0;
        cyc(); cyc();
        chk("simul_no_strobe", 32'(n_min + n_hrs + n_day), 0);
        repeat (4) press_mode();
        chk("back_to_run", 32'(mode), 0);

        // alarm ring, snooze, resume, auto-stop
        sw = 1'b1;
        cyc();
        match = 1'b1;
        cyc();
        chk("ring_start", 32'(buzz), 1);
        tick = 1'b1;
        repeat (9) cyc();
        snz_b = 1'b1;
        cyc();
        snz_b = 1'b0;
        chk("snooze_buzz", 32'(buzz), 0);
        chk("snooze_flag", 32'(snoozing), 1);
        for (int k = 1; k <= SNOOZE_SEC; k++) begin
            cyc();
            if (k == SNOOZE_SEC - 1) chk("snooze_before_end", 32'(buzz), 0);
        end
        chk("ring_resume", 32'(buzz), 1);
        for (int k = 1; k <= RING_SEC; k++) begin
            cyc();
            if (k == RING_SEC - 1) chk("ring_before_stop", 32'(buzz), 1);
        end
        chk("ring_autostop", 32'(buzz), 0);
        tick = 1'b0;
        match = 1'b0;
        cyc();

        // alarm_sw drop while ringing
        match = 1'b1; cyc();
        chk("ring_again", 32'(buzz), 1);
        sw = 1'b0; cyc();
        chk("sw_off_buzz", 32'(buzz), 0);
        sw = 1'b1; match = 1'b0; cyc();

        // snooze, enter a set state, then asynchronous reset
        match = 1'b1; cyc();
        snz_b = 1'b1; cyc();
        snz_b = 1'b0;
        press_mode();
        chk("snooze_in_set", 32'(snoozing), 1);
        chk("set_during_snooze", 32'(mode), 1);
        rst_b = 1'b0;
        #1;
        chk("async_reset_outs",
            32'({timeset, alarmset, minadv, hrsadv, dayadv, mode, buzz, snoozing}), 0);
        cyc();
        rst_b = 1'b1; match = 1'b0;
        cyc();

        // random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode_b = ~mode_b;
            if ($urandom_range(0, 9) == 0) adv_b = ~adv_b;
            if ($urandom_range(0, 7) == 0) snz_b = ~snz_b;
            if ($urandom_range(0, 19) == 0) match = ~match;
            if ($urandom_range(0, 199) == 0) sw = ~sw;
            tick = ($urandom_range(0, 2) == 0);
            rst_b = ($urandom_range(0, 1499) != 0);
            cyc();
        end
        rst_b = 1'b1; tick = 1'b0;
        cyc(); cyc();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Front-panel controller for the alarm clock datapath (seconds/minutes/hours/day counters, alarm registers, alarm comparator).
- Turns three debounced buttons plus the alarm switch into the set-mode and advance-enable strobes that the counters consume.
- Also owns the alarm ring/snooze sequencing, so a single "mode" button and a single "adv" button replace the separate Timeset/Alarmset/Minadv/Hrsadv/Dayadv inputs.

Parameters:
- RPT_DLY, 2: sec_ticks an adv hold must last before auto-repeat starts.
- IDLE_TO, 30: sec_ticks without a button edge in any set state before forced return to RUN.
- RING_SEC, 60: sec_ticks the buzzer sounds before auto-stop.
- SNOOZE_SEC, 540: sec_ticks of snooze before ringing resumes.

Ports:
- clk  in  1  system clock (also clocks the counters)
- rst  in  1  asynchronous, active-low reset
- sec_tick  in  1  one-clk strobe, once per second
- mode_btn  in  1  debounced, clk-synchronous level
- adv_btn  in  1  debounced, clk-synchronous level
- snooze_btn  in  1  debounced, clk-synchronous level
- alarm_sw  in  1  alarm enable switch (level)
- alarm_match  in  1  comparator output: current time equals alarm time (level)
- timeset  out  1  high in T_MIN / T_HRS / T_DAY
- alarmset  out  1  high in A_MIN / A_HRS
- minadv  out  1  one-clk advance strobe
- hrsadv  out  1  one-clk advance strobe
- dayadv  out  1  one-clk advance strobe
- mode  out  3  encoded panel state
- buzz  out  1  alarm sounding
- snoozing  out  1  snooze active

Behaviour:
- Reset (rst=0, asynchronous):
  - panel state = RUN; alarm state = A_IDLE.
  - All outputs 0; mode=0.
  - Edge-detect registers, repeat counter, idle counter and ring/snooze counter cleared.
- Edge detection: a rising edge is btn=1 while the previous-clk registered value=0. A button already held when reset releases produces no edge.
- Panel FSM, encoding RUN=0, T_MIN=1, T_HRS=2, T_DAY=3, A_MIN=4, A_HRS=5:
  - mode_btn rising edge: RUN→T_MIN→T_HRS→T_DAY→A_MIN→A_HRS→RUN.
  - Encodings 6 and 7 are illegal and go to RUN on the next clk.
- Outputs are registered and change one clk after the causing edge.
  - timeset and alarmset decode from the state.
  - mode equals the state encoding.
- Advance strobes, which pulse depends on state:
  - minadv in T_MIN or A_MIN.
  - hrsadv in T_HRS or A_HRS.
  - dayadv in T_DAY.
  - In RUN, adv_btn is ignored and no strobe is produced.
- adv_btn rising edge in a set state: one strobe, exactly 1 clk wide.
- Auto-repeat while adv_btn stays high:
  - The repeat counter counts sec_ticks.
  - Once the count reaches RPT_DLY, every further sec_tick produces one strobe, in the clk after the tick.
  - Releasing the button clears the counter.
- Simultaneous mode_btn and adv_btn edges in the same clk: the mode transition wins, no strobe is issued, and the repeat counter clears.
- At most one advance strobe is high in any clk.
- Idle timeout in a set state:
  - The idle counter increments on sec_tick.
  - It clears on state entry, on any mode/adv edge, and on every clk where adv_btn is high.
  - When it reaches IDLE_TO the panel goes to RUN; no strobe is issued that clk.
- Alarm FSM, states A_IDLE, A_RING, A_SNOOZE:
  - A_IDLE→A_RING: on a rising edge of alarm_match while alarm_sw=1 and panel=RUN. The ring counter clears.
  - A_RING→A_IDLE: after RING_SEC sec_ticks.
  - A_RING→A_SNOOZE: on a snooze_btn rising edge; the counter clears.
  - A_SNOOZE→A_RING: after SNOOZE_SEC sec_ticks; the counter clears.
  - snooze_btn edges in A_IDLE or A_SNOOZE are ignored.
  - alarm_sw=0 in any state forces A_IDLE on the next clk. This overrides every other transition in the same clk.
  - Entering a set state does not disturb A_RING or A_SNOOZE. A new A_IDLE→A_RING trigger needs panel=RUN.
- Alarm outputs:
  - buzz=1 only in A_RING.
  - snoozing=1 only in A_SNOOZE.
- Counter widths:
  - Ring/snooze counter: $clog2(max(RING_SEC,SNOOZE_SEC)+1) bits.
  - Idle counter: $clog2(IDLE_TO+1) bits.
  - Repeat counter saturates at RPT_DLY.
  - No counter may wrap.

Test Plan:
- Reset, then five mode_btn presses: mode steps 1,2,3,4,5; timeset=1 for 1–3, alarmset=1 for 4–5. Sixth press → mode=0, both flags 0.
- In T_MIN, tap adv_btn for 3 clks (no sec_tick): exactly one 1-clk minadv, no hrsadv/dayadv. In RUN the same tap gives no strobe.
- In A_HRS, hold adv_btn across 6 sec_ticks with RPT_DLY=2: hrsadv count = 1 (edge) + 4 (ticks 3–6) = 5.
- In T_DAY, no buttons for 30 sec_ticks → mode=0 on the clk after the 30th tick, dayadv never pulses. mode_btn and adv_btn rising in the same clk in T_MIN → mode=2, no minadv.
- alarm_sw=1, alarm_match rises in RUN → buzz=1. snooze_btn at tick 10 → buzz=0, snoozing=1. 540 ticks later buzz=1 again; 60 ticks later buzz=0.
- While ringing, drop alarm_sw → buzz=0 next clk. Assert rst low mid-snooze → all outputs 0 immediately (asynchronous), mode=0.
